// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan driver: hex decode, per-digit decimal points, PWM
// brightness, leading-zero blanking and frame-synchronous double-buffered updates.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_LOG2       = 15,
  parameter int BRIGHT_BITS    = 4,
  parameter int GND_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   grounds,
  output logic [6:0]              display,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int                    IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic                  GND_OFF     = (GND_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] GND_ALL_OFF = {NUM_DIGITS{GND_OFF}};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      4'hF:    seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [DIV_LOG2-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_nib_q, pend_nib_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_nib_q, act_nib_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   grounds_q, grounds_d;
  logic [6:0]              display_q, display_d;
  logic                    dp_q, dp_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_tick_s;
  logic                    frame_bnd_s;
  logic [BRIGHT_BITS-1:0]  phase_s;
  logic                    pwm_on_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;

  // Prescaler and digit index sequencing.
  always_comb begin
    slot_tick_s = &presc_q;
    frame_bnd_s = slot_tick_s && (idx_q == LAST_IDX);
    presc_d     = presc_q + DIV_LOG2'(1);
    if (slot_tick_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    frame_tick_d = frame_bnd_s;
  end

  // Double buffer: pending collects loads, active swaps only on a frame boundary.
  always_comb begin
    pend_nib_d   = pend_nib_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_nib_d    = act_nib_q;
    act_dp_d     = act_dp_q;
    if (load) begin
      pend_nib_d = din;
      pend_dp_d  = dp_in;
      if (frame_bnd_s) begin
        // Load on the boundary itself goes straight to the scan, skipping a frame of delay.
        act_nib_d    = din;
        act_dp_d     = dp_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
      end
    end else if (frame_bnd_s && pend_valid_q) begin
      act_nib_d    = pend_nib_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Leading-zero run: lz_s[i] set when nibbles NUM_DIGITS-1..i of active are all zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_s     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_nib_q[4*i +: 4] == 4'h0);
      lz_s[i]  = zero_run;
    end
  end

  // Select the nibble, decimal point and blanking flag for the digit being scanned.
  always_comb begin
    sel_s     = '0;
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    cur_lz_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_s[i]  = 1'b1;
        cur_nib_s = act_nib_q[4*i +: 4];
        cur_dp_s  = act_dp_q[i];
        cur_lz_s  = (i != 0) ? lz_s[i] : 1'b0;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Output drive: PWM-gated ground, decoded segments and decimal point.
  always_comb begin
    phase_s  = presc_q[DIV_LOG2-1 -: BRIGHT_BITS];
    pwm_on_s = (phase_s < brightness);
    if (pwm_on_s) begin
      grounds_d = (GND_OFF == 1'b1) ? ~sel_s : sel_s;
    end else begin
      grounds_d = GND_ALL_OFF;
    end
    if (blank_lz && cur_lz_s) begin
      display_d = 7'b0000000;
    end else begin
      display_d = seg_decode(cur_nib_s);
    end
    dp_d = cur_dp_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_nib_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_nib_q    <= '0;
      act_dp_q     <= '0;
      grounds_q    <= GND_ALL_OFF;
      display_q    <= 7'b0000000;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_nib_q   <= pend_nib_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_nib_q    <= act_nib_d;
      act_dp_q     <= act_dp_d;
      grounds_q    <= grounds_d;
      display_q    <= display_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign grounds    = grounds_q;
  assign display    = display_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
